// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (LSB first) with a show-ahead receive FIFO.
// rx is synchronized, sampled at mid-bit, and completed bytes are pushed
// into a circular FIFO read over a valid/ready port. Framing errors and
// overruns are reported as single-cycle pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t                         state;
  logic [CW-1:0]                  cnt;
  logic [2:0]                     idx;
  logic [7:0]                     shreg;
  logic [1:0]                     sync;
  logic                           rx_s;
  logic                           push, pop, full, wr_en;
  logic [AW-1:0]                  wptr, rptr;
  logic [AW:0]                    count_nxt;
  logic [FIFO_DEPTH-1:0][7:0]     mem;

  assign rx_s = sync[1];

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end

  // A byte is complete when the stop bit samples high; shreg is fully
  // loaded by then, so it feeds the FIFO write directly.
  assign push = (state == STOP) && (cnt == LAST) && rx_s;

  // Receive FSM: mid-bit sampling driven by a single bit-timing counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            // a line that is high again at mid start bit was a glitch
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            shreg[idx] <= rx_s;
            cnt        <= '0;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          // a break keeps us here, so it reports only one framing error
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO control: a pop in the same cycle frees room for a push when full
  assign pop   = rd_valid && rd_ready;
  assign full  = (fifo_count == FULL);
  assign wr_en = push && (!full || pop);

  // Next occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    count_nxt = fifo_count;
    if (wr_en && !pop)      count_nxt = fifo_count + (AW+1)'(1);
    else if (!wr_en && pop) count_nxt = fifo_count - (AW+1)'(1);
  end

  // Pointers, count and status flags; rd_valid is registered from count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      rd_valid   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      fifo_count <= count_nxt;
      rd_valid   <= (count_nxt != '0);
      overrun    <= push && full && !pop;
    end
  end

  // Storage needs no reset; contents are only observed while rd_valid
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= shreg;
  end

  assign rd_data = mem[rptr];

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed UART frames checked against a queue-based model of
// the receive FIFO, with frame outcomes scheduled from the bit timing.
module tb_uart_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  // falling pin edge driven just after posedge n -> stop sample on posedge n+155
  localparam int STOP_OFS = 155;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, frame_err, overrun;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .frame_err(frame_err), .overrun(overrun), .fifo_count(fifo_count)
  );

  int checks = 0, errors = 0, cyc = 0;
  int ferr_cnt = 0, ovr_cnt = 0, rise_cyc = -1;
  bit prev_v = 1'b0;
  logic [7:0] q[$];
  logic [7:0] push_at[int];
  bit         ferr_at[int];
  bit         m_ferr = 1'b0, m_ovr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a queue of received bytes; frame outcomes land at their scheduled edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); push_at.delete(); ferr_at.delete();
      m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      cyc++;
      m_ferr = 1'b0; m_ovr = 1'b0;
      if (rd_ready && q.size() != 0) void'(q.pop_front());
      if (ferr_at.exists(cyc)) m_ferr = 1'b1;
      if (push_at.exists(cyc)) begin
        if (q.size() < DEPTH) q.push_back(push_at[cyc]);
        else                  m_ovr = 1'b1;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (rd_valid && !prev_v) rise_cyc = cyc;
      prev_v = rd_valid;
    end
  end

  // Drive one 8N1 frame starting at a negedge; schedules the expected outcome
  task automatic send_frame(input logic [7:0] b, input bit stop);
    int n;
    n = cyc;
    if (stop) push_at[n + STOP_OFS] = b;
    else      ferr_at[n + STOP_OFS] = 1'b1;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pop_one(input logic [7:0] exp, input string nm);
    chk({nm, "_valid"}, 32'(rd_valid), 32'd1);
    chk({nm, "_data"}, 32'(rd_data), 32'(exp));
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, p, o, f, guard;
    logic [7:0] b;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // single byte: rd_valid rises exactly after the stop-sample edge
    n0 = cyc;
    send_frame(8'hA5, 1'b1);
    chk("s1_rise", 32'(rise_cyc), 32'(n0 + 155));
    chk("s1_data", 32'(rd_data), 32'hA5);
    chk("s1_count", 32'(fifo_count), 32'd1);
    pop_one(8'hA5, "s1_pop");
    chk("s1_empty_valid", 32'(rd_valid), 32'd0);
    chk("s1_empty_count", 32'(fifo_count), 32'd0);
    repeat (10) @(negedge clk);

    // back-to-back frames and overrun on the fifth
    o = ovr_cnt;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1);
    end
    repeat (2) @(negedge clk);
    chk("s2_overruns", 32'(ovr_cnt - o), 32'd1);
    chk("s2_count", 32'(fifo_count), 32'd4);
    pop_one(8'h01, "s2_d1");
    pop_one(8'h02, "s2_d2");
    pop_one(8'h03, "s2_d3");
    pop_one(8'h04, "s2_d4");
    chk("s2_drained", 32'(fifo_count), 32'd0);
    repeat (10) @(negedge clk);

    // full FIFO with a pop on the exact push edge of 0x55
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1);
    end
    o = ovr_cnt;
    p = cyc + STOP_OFS;
    fork
      send_frame(8'h55, 1'b1);
      begin
        guard = 0;
        while (cyc != p - 1 && guard < 400) begin
          @(negedge clk);
          guard++;
        end
        chk("s3_align", 32'(cyc), 32'(p - 1));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
      end
    join
    chk("s3_overruns", 32'(ovr_cnt - o), 32'd0);
    chk("s3_count", 32'(fifo_count), 32'd4);
    pop_one(8'h02, "s3_d1");
    pop_one(8'h03, "s3_d2");
    pop_one(8'h04, "s3_d3");
    pop_one(8'h55, "s3_d4");
    repeat (10) @(negedge clk);

    // framing error followed by a 40-bit break
    f = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    chk("s4_ferrs", 32'(ferr_cnt - f), 32'd1);
    chk("s4_count", 32'(fifo_count), 32'd0);
    send_frame(8'h7E, 1'b1);
    chk("s4_next_count", 32'(fifo_count), 32'd1);
    pop_one(8'h7E, "s4_next");
    repeat (10) @(negedge clk);

    // 4-cycle start glitch is rejected silently
    f = ferr_cnt;
    o = ovr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("s5_count", 32'(fifo_count), 32'd0);
    chk("s5_flags", 32'((ferr_cnt - f) + (ovr_cnt - o)), 32'd0);
    send_frame(8'hC3, 1'b1);
    chk("s5_count2", 32'(fifo_count), 32'd1);
    chk("s5_data", 32'(rd_data), 32'hC3);

    // reset during data bit 4 of 0xFF, with 0xC3 still held in the FIFO
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("s6_valid", 32'(rd_valid), 32'd0);
    chk("s6_count", 32'(fifo_count), 32'd0);
    chk("s6_ferr", 32'(frame_err), 32'd0);
    chk("s6_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h81, 1'b1);
    chk("s6_count2", 32'(fifo_count), 32'd1);
    chk("s6_data", 32'(rd_data), 32'h81);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
